alu_mp_seq: RTL and testbench

Multi-precision sequencer that acts as the driver of the N-bit combinational ALU. It accepts a W*N-bit operation request with a start/busy/done handshake. It then issues the request to the ALU one N-bit word per cycle, least-significant word first, and chains the carry between words. It assembles the full-width result and its flags. It sits between the calculator control unit and one ALU instance, and uses the operation codes from the shared ALU interface include (AC_AD, AC_SB, AC_AN, AC_OR, AC_LS).

---
 rtl/alu_mp_seq.sv | 158 +++++++++++++++
 tb/tb_alu_mp_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer: drives one N-bit ALU word by word, LS word first,
// chaining the carry to build a W*N-bit result with carry and zero flags.
module alu_mp_seq #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 4,
  parameter int unsigned AC_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AC_N-1:0]   op,
  input  logic [W*N-1:0]    a_in,
  input  logic [W*N-1:0]    b_in,
  output logic              busy,
  output logic              done,
  output logic [W*N-1:0]    result,
  output logic              carry,
  output logic              zero,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic              alu_cin,
  output logic [AC_N-1:0]   alu_cs,
  input  logic [N-1:0]      alu_s,
  input  logic              alu_zero,
  input  logic              alu_cout
);

  localparam int unsigned DW = W * N;
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  localparam logic [AC_N-1:0] AC_AD = AC_N'(0);
  localparam logic [AC_N-1:0] AC_SB = AC_N'(1);
  localparam logic [AC_N-1:0] AC_AN = AC_N'(2);
  localparam logic [AC_N-1:0] AC_OR = AC_N'(3);
  localparam logic [AC_N-1:0] AC_LS = AC_N'(4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [IW-1:0]   idx;
  logic            cr;
  logic [AC_N-1:0] op_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [DW-1:0]   res_run_c;
  logic            last_c;
  logic            arith_c;
  logic            unused_alu_zero;

  assign unused_alu_zero = alu_zero;
  assign last_c  = (idx == IW'(W - 1));
  assign arith_c = (op_q == AC_AD) || (op_q == AC_SB) || (op_q == AC_LS);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive for the current word; parked on AND of zeros outside RUN
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_cs  = AC_AN;
    if (state_q == S_RUN) begin
      case (op_q)
        AC_AD: begin
          alu_cs  = AC_AD;
          alu_a   = a_q[idx*N +: N];
          alu_b   = b_q[idx*N +: N];
          alu_cin = cr;
        end
        AC_SB, AC_LS: begin
          alu_cs  = AC_AD;
          alu_a   = a_q[idx*N +: N];
          alu_b   = ~b_q[idx*N +: N];
          alu_cin = cr;
        end
        AC_AN: begin
          alu_cs = AC_AN;
          alu_a  = a_q[idx*N +: N];
          alu_b  = b_q[idx*N +: N];
        end
        AC_OR: begin
          alu_cs = AC_OR;
          alu_a  = a_q[idx*N +: N];
          alu_b  = b_q[idx*N +: N];
        end
        default: begin
          alu_cs = AC_AN;
        end
      endcase
    end
  end

  // Result after this RUN edge; compare only writes its flag on the last word
  always_comb begin
    res_run_c = result;
    if (op_q == AC_LS) begin
      if (last_c) res_run_c = DW'(!alu_cout);
    end else begin
      res_run_c[idx*N +: N] = alu_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx     <= '0;
      cr      <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b1;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= a_in;
            b_q    <= b_in;
            result <= '0;
            idx    <= '0;
            cr     <= (op == AC_SB) || (op == AC_LS);
          end
        end
        S_RUN: begin
          result <= res_run_c;
          cr     <= arith_c ? alu_cout : 1'b0;
          idx    <= last_c ? '0 : idx + IW'(1);
          if (last_c) begin
            carry <= ((op_q == AC_AD) || (op_q == AC_SB)) ? alu_cout : 1'b0;
            zero  <= (res_run_c == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Self-checking bench for alu_mp_seq with a behavioural N-bit ALU attached.
module tb_alu_mp_seq;

  localparam int unsigned N    = 8;
  localparam int unsigned W    = 4;
  localparam int unsigned AC_N = 3;
  localparam int unsigned DW   = W * N;

  localparam logic [2:0] AC_AD = 3'd0;
  localparam logic [2:0] AC_SB = 3'd1;
  localparam logic [2:0] AC_AN = 3'd2;
  localparam logic [2:0] AC_OR = 3'd3;
  localparam logic [2:0] AC_LS = 3'd4;

  logic            clk;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [DW-1:0]   a_in;
  logic [DW-1:0]   b_in;
  logic            busy;
  logic            done;
  logic [DW-1:0]   result;
  logic            carry;
  logic            zero;
  logic [N-1:0]    alu_a;
  logic [N-1:0]    alu_b;
  logic            alu_cin;
  logic [2:0]      alu_cs;
  logic [N-1:0]    alu_s;
  logic            alu_zero;
  logic            alu_cout;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 0;

  alu_mp_seq #(.N(N), .W(W), .AC_N(AC_N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_cs(alu_cs),
    .alu_s(alu_s), .alu_zero(alu_zero), .alu_cout(alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural N-bit ALU
  always_comb begin
    alu_s    = '0;
    alu_cout = 1'b0;
    case (alu_cs)
      AC_AD:   {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      AC_AN:   alu_s = alu_a & alu_b;
      AC_OR:   alu_s = alu_a | alu_b;
      default: alu_s = '0;
    endcase
    alu_zero = (alu_s == '0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full-width reference: {carry, result}
  function automatic logic [DW:0] ref_op(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (o)
      AC_AD:   return {1'b0, a} + {1'b0, b};
      AC_SB:   return {(a >= b), a - b};
      AC_LS:   return {1'b0, DW'(a < b)};
      AC_AN:   return {1'b0, a & b};
      AC_OR:   return {1'b0, a | b};
      default: return '0;
    endcase
  endfunction

  // Transaction model: cnt counts down the W+1 busy cycles
  int            cnt;
  logic [2:0]    m_op;
  logic [DW-1:0] m_a, m_b, m_res_pend, exp_res;
  logic          m_c_pend, exp_c, exp_z;
  logic [W-1:0]  cin_log;

  always @(posedge clk) begin
    if (rst) begin
      cnt     <= 0;
      exp_res <= '0;
      exp_c   <= 1'b0;
      exp_z   <= 1'b1;
    end else if (cnt == 0) begin
      if (start) begin
        cnt  <= W + 1;
        m_op <= op;
        m_a  <= a_in;
        m_b  <= b_in;
        {m_c_pend, m_res_pend} <= ref_op(op, a_in, b_in);
      end
    end else begin
      cnt <= cnt - 1;
      if (cnt == 2) begin
        exp_res <= m_res_pend;
        exp_c   <= m_c_pend;
        exp_z   <= (m_res_pend == '0);
      end
    end
  end

  always @(negedge clk) begin : cmp
    int            k;
    logic [N-1:0]  ea, eb;
    logic          ec;
    logic [2:0]    ecs;
    logic [DW-1:0] bb;
    logic [63:0]   msk, sum;
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(cnt > 0));
      chk("done", 64'(done), 64'(cnt == 1));
      if (cnt <= 1) begin
        chk("result", 64'(result), 64'(exp_res));
        chk("carry", 64'(carry), 64'(exp_c));
        chk("zero", 64'(zero), 64'(exp_z));
        chk("idle_alu_a", 64'(alu_a), 64'd0);
        chk("idle_alu_b", 64'(alu_b), 64'd0);
        chk("idle_alu_cin", 64'(alu_cin), 64'd0);
        chk("idle_alu_cs", 64'(alu_cs), 64'(AC_AN));
      end else begin
        k   = W + 1 - cnt;
        ea  = '0;
        eb  = '0;
        ec  = 1'b0;
        ecs = AC_AN;
        case (m_op)
          AC_AD, AC_SB, AC_LS: begin
            bb  = (m_op == AC_AD) ? m_b : ~m_b;
            ecs = AC_AD;
            ea  = m_a[k*N +: N];
            eb  = bb[k*N +: N];
            msk = (64'd1 << (k * N)) - 64'd1;
            sum = ({32'd0, m_a} & msk) + ({32'd0, bb} & msk) + 64'(m_op != AC_AD);
            ec  = sum[k*N];
          end
          AC_AN, AC_OR: begin
            ecs = m_op;
            ea  = m_a[k*N +: N];
            eb  = m_b[k*N +: N];
          end
          default: begin
          end
        endcase
        chk("run_alu_a", 64'(alu_a), 64'(ea));
        chk("run_alu_b", 64'(alu_b), 64'(eb));
        chk("run_alu_cin", 64'(alu_cin), 64'(ec));
        chk("run_alu_cs", 64'(alu_cs), 64'(ecs));
        cin_log[k] = alu_cin;
      end
    end
  end

  task automatic run(input string name, input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [DW-1:0] er, input logic ec, input logic ez);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'd5);
    chk({name, "_busy_cycles"}, 64'(nbusy), 64'd5);
    chk({name, "_result"}, 64'(result), 64'(er));
    chk({name, "_carry"}, 64'(carry), 64'(ec));
    chk({name, "_zero"}, 64'(zero), 64'(ez));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a_in  = '0;
    b_in  = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_zero", 64'(zero), 64'd1);

    run("ad_ff_1", AC_AD, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
    run("ad_wrap", AC_AD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
    chk("ad_wrap_cin_words", 64'(cin_log), 64'b1110);
    run("sb_100_1", AC_SB, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0);
    run("sb_0_1", AC_SB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("ls_ge", AC_LS, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    run("ls_lt", AC_LS, 32'h0000_FFFF, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0);
    run("an", AC_AN, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
    run("or", AC_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0);
    run("bad_op", 3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b1);

    // start pulses during RUN and during DONE are both ignored
    @(negedge clk);
    op = AC_AD; a_in = 32'h0000_0001; b_in = 32'h0000_0002; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    op = AC_OR; a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("ignore_run_done", 64'(done), 64'd1);
    chk("ignore_run_result", 64'(result), 64'h3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ignore_done_busy", 64'(busy), 64'd0);
    chk("ignore_done_result", 64'(result), 64'h3);

    // reset while RUN is on word 2
    @(negedge clk);
    op = AC_AD; a_in = 32'h1234_5678; b_in = 32'h0000_0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_zero", 64'(zero), 64'd1);
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
